// File: rtl/demux_pkg.sv
// Shared constants, slot types and a popcount helper for the 1-to-8 5-bit registered demux.
package demux_pkg;

  localparam int WIDTH = 5;
  localparam int N     = 8;
  localparam int SEL_W = $clog2(N);

  typedef logic [WIDTH-1:0] slot_data_t;
  typedef logic [SEL_W-1:0] slot_sel_t;
  typedef logic [SEL_W:0]   occ_t;

  // Number of set bits in a slot mask, wide enough to hold N itself.
  function automatic occ_t popcount(input logic [N-1:0] mask);
    occ_t cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + occ_t'(mask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One demux slot: a data register plus a full/empty flag.
// A write always reloads the data and marks the slot full; an ack without a
// write empties it. The data is never cleared by an ack.
module demux_slot
  import demux_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr,
  input  logic       ack,
  input  slot_data_t d,
  output slot_data_t q,
  output logic       valid
);

  slot_data_t q_q, q_d;
  logic       valid_q, valid_d;

  // Next state: write wins over ack, so write+ack keeps the slot full.
  always_comb begin
    q_d     = wr ? d : q_q;
    valid_d = wr | (valid_q & ~ack);
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;

endmodule

// File: rtl/demux8pra5bits_reg.sv
// Registered 1-to-8 demultiplexer for 5-bit values with a valid/ready write
// port, per-slot consumer acks, an occupancy counter and an empty-ack flag.
module demux8pra5bits_reg
  import demux_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  slot_sel_t             controlador,
  input  slot_data_t            inputDemux,
  output slot_data_t [N-1:0]    dout,
  output logic [N-1:0]          out_valid,
  input  logic [N-1:0]          out_ack,
  output logic [SEL_W:0]        occupancy,
  output logic                  ack_err
);

  logic         accept;
  logic [N-1:0] wr_dec;
  logic [N-1:0] ack_eff;
  logic [N-1:0] ack_empty;
  occ_t         occ_q, occ_d;
  logic         ack_err_q, ack_err_d;

  // Ready mux: the addressed slot must be empty or draining this cycle.
  // Held low during reset so no write can be handshaked then.
  always_comb begin
    in_ready = reset_n && (!out_valid[controlador] || out_ack[controlador]);
    accept   = in_valid && in_ready;
  end

  // One-hot write decoder driven only by an accepted handshake.
  always_comb begin
    wr_dec = '0;
    if (accept) wr_dec[controlador] = 1'b1;
  end

  // Split acks into those that consume data and those hitting empty slots.
  always_comb begin
    ack_eff   = out_ack & out_valid;
    ack_empty = out_ack & ~out_valid;
  end

  generate
    for (genvar g = 0; g < N; g++) begin : g_slot
      demux_slot u_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr_dec[g]),
        .ack     (ack_eff[g]),
        .d       (inputDemux),
        .q       (dout[g]),
        .valid   (out_valid[g])
      );
    end
  endgenerate

  // Occupancy next state: a write+ack on the same slot nets to zero because
  // the write adds one and the ack on that full slot removes one.
  always_comb begin
    occ_d     = occ_q + occ_t'(accept) - popcount(ack_eff);
    ack_err_d = |ack_empty;
  end

  // Occupancy counter and single-cycle empty-ack flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign occupancy = occ_q;
  assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_demux8pra5bits_reg.sv
// Bench for demux8pra5bits_reg: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a slot-array model.
module tb_demux8pra5bits_reg;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       controlador;
  logic [4:0]       inputDemux;
  logic [7:0][4:0]  dout;
  logic [7:0]       out_valid;
  logic [7:0]       out_ack;
  logic [3:0]       occupancy;
  logic             ack_err;

  demux8pra5bits_reg dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .controlador (controlador),
    .inputDemux  (inputDemux),
    .dout        (dout),
    .out_valid   (out_valid),
    .out_ack     (out_ack),
    .occupancy   (occupancy),
    .ack_err     (ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Reference model: slot contents and full flags as plain arrays.
  logic [7:0]      mv;
  logic [7:0][4:0] md;
  logic            merr;

  function automatic logic [7:0] next_valid(input logic [7:0] v, input logic iv,
                                            input logic [2:0] s, input logic [7:0] a);
    logic [7:0] r;
    r = v & ~a;
    if (iv && (!v[s] || a[s])) r[s] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mv   <= '0;
      md   <= '0;
      merr <= 1'b0;
    end else begin
      mv   <= next_valid(mv, in_valid, controlador, out_ack);
      merr <= |(out_ack & ~mv);
      if (in_valid && (!mv[controlador] || out_ack[controlador]))
        md[controlador] <= inputDemux;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: registered outputs and combinational ready, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_dout",      64'(dout),      64'(md));
      chk("m_out_valid", 64'(out_valid), 64'(mv));
      chk("m_occupancy", 64'(occupancy), 64'($countones(mv)));
      chk("m_ack_err",   64'(ack_err),   64'(merr));
      chk("m_in_ready",  64'(in_ready),
          64'(reset_n && (!mv[controlador] || out_ack[controlador])));
    end
  end

  // Present inputs for one cycle, take the edge, then idle the inputs.
  task automatic step(input logic v, input logic [2:0] s, input logic [4:0] d, input logic [7:0] a);
    in_valid = v; controlador = s; inputDemux = d; out_ack = a;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ack = '0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; controlador = '0; inputDemux = '0; out_ack = '0;
    @(posedge clk); #1;
    chk_en = 1;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_occ",   64'(occupancy), 64'h0);
    chk("rst_ready", 64'(in_ready),  64'h0);
    chk("rst_dout",  64'(dout),      64'h0);
    reset_n = 1'b1;

    // Single write then ack.
    step(1, 3'd3, 5'h1A, 8'h00);
    chk("w3_dout",  64'(dout[3]),   64'h1A);
    chk("w3_valid", 64'(out_valid), 64'h08);
    chk("w3_occ",   64'(occupancy), 64'h1);
    chk("model_w3", 64'(md[3]),     64'h1A);
    step(0, 3'd0, 5'h00, 8'h08);
    chk("a3_valid", 64'(out_valid), 64'h00);
    chk("a3_dout",  64'(dout[3]),   64'h1A);
    chk("a3_occ",   64'(occupancy), 64'h0);

    // Fill every slot with i+1, then a blocked write to slot 0.
    for (int i = 0; i < 8; i++) step(1, 3'(i), 5'(i + 1), 8'h00);
    chk("full_occ",   64'(occupancy), 64'h8);
    chk("full_valid", 64'(out_valid), 64'hFF);
    in_valid = 1'b1; controlador = 3'd0; inputDemux = 5'h15; out_ack = '0;
    #1;
    chk("full_ready", 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_d0",  64'(dout[0]),   64'h01);
    chk("full_occ2", 64'(occupancy), 64'h8);

    // Drain all, put 5'h07 in slot 4, then write 5'h1F while acking slot 4.
    step(0, 3'd0, 5'h00, 8'hFF);
    chk("drain_occ", 64'(occupancy), 64'h0);
    step(1, 3'd4, 5'h07, 8'h00);
    chk("s4_d", 64'(dout[4]), 64'h07);
    step(1, 3'd4, 5'h1F, 8'h10);
    chk("wa4_dout",  64'(dout[4]),   64'h1F);
    chk("wa4_valid", 64'(out_valid), 64'h10);
    chk("wa4_occ",   64'(occupancy), 64'h1);
    step(0, 3'd0, 5'h00, 8'h10);

    // Slots 0,1,6 full; ack them plus empty slot 7.
    step(1, 3'd0, 5'h0A, 8'h00);
    step(1, 3'd1, 5'h0B, 8'h00);
    step(1, 3'd6, 5'h0C, 8'h00);
    chk("m3_occ", 64'(occupancy), 64'h3);
    step(0, 3'd0, 5'h00, 8'hC3);
    chk("m3_occ_after", 64'(occupancy), 64'h0);
    chk("m3_err",       64'(ack_err),   64'h1);
    step(0, 3'd0, 5'h00, 8'h00);
    chk("m3_err_clr",   64'(ack_err),   64'h0);

    // Write slot 2 while acking slot 6.
    step(1, 3'd6, 5'h11, 8'h00);
    step(1, 3'd2, 5'h12, 8'h40);
    chk("xw_occ",   64'(occupancy), 64'h1);
    chk("xw_valid", 64'(out_valid), 64'h04);
    step(0, 3'd0, 5'h00, 8'h04);

    // Asynchronous reset mid-cycle with slots 2 and 5 full.
    step(1, 3'd2, 5'h02, 8'h00);
    step(1, 3'd5, 5'h05, 8'h00);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_dout",  64'(dout),      64'h0);
    chk("ar_valid", 64'(out_valid), 64'h0);
    chk("ar_occ",   64'(occupancy), 64'h0);
    chk("ar_ready", 64'(in_ready),  64'h0);
    step(1, 3'd1, 5'h09, 8'h00);
    chk("ar_ignored", 64'(out_valid), 64'h0);
    reset_n = 1'b1;
    step(1, 3'd1, 5'h09, 8'h00);
    chk("ar_first_w", 64'(out_valid), 64'h02);

    // Randomized traffic; acks sparse enough to let slots fill up.
    for (int c = 0; c < 600; c++) begin
      logic [7:0] a;
      a = 8'($urandom) & 8'($urandom) & 8'($urandom);
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), 5'($urandom), a);
    end

    @(posedge clk); #1;
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
